vx_ibuf_credit: RTL
===================

# VX_ibuf_credit

Fetch-side flow-control tracker for the per-issue-slice instruction buffers. The warp scheduler reserves an instruction-buffer slot before launching a fetch. The slot is returned when the instruction buffer pops that instruction to issue, or when the instruction is cancelled upstream of the buffer. This guarantees that an instruction buffer is never offered an instruction it cannot hold. The block also reports per-warp "no instruction in flight" status, which barrier and wspawn logic use.

## Interface
Parameters:
- CORE_ID, 0, core index; debug only.
- NUM_WARPS, `NUM_WARPS, warps per core.
- ISSUE_CNT, `ISSUE_WIDTH, number of issue slices / instruction buffers.
- CREDITS, `IBUF_SIZE, slots per slice; must be ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  scheduler wants to fetch for req_wid.
- req_wid  in  NW_WIDTH  requesting warp.
- req_ready  out  1  slice wid_to_isw(req_wid) has a free credit.
- pop  in  ISSUE_CNT  per-slice instruction-buffer pop (valid && ready at buffer output).
- pop_wis  in  ISSUE_CNT×ISSUE_WIS_W  warp-in-slice of each pop.
- cancel_valid  in  1  instruction dropped before reaching a buffer (fetch flush, decode kill).
- cancel_wid  in  NW_WIDTH  warp of the cancelled instruction.
- warp_idle  out  NUM_WARPS  bit w = 1 when warp w has zero reserved instructions.
- all_idle  out  1  AND of warp_idle.

## Operation
- Warp mapping: isw = wid_to_isw(wid) = wid % ISSUE_CNT; wis = wid_to_wis(wid) = wid / ISSUE_CNT. A pop on slice i with wis k belongs to wid = wis_to_wid(k, i) = k*ISSUE_CNT + i.
- State:
  - credit[ISSUE_CNT], width CNTW = $clog2(CREDITS+1).
  - inflight[NUM_WARPS], width CNTW.
- Reserve fire is req_valid && req_ready. It decrements credit[isw] and increments inflight[req_wid].
- Each pop[i] increments credit[i] and decrements inflight[wis_to_wid(pop_wis[i], i)].
- A cancel increments credit[wid_to_isw(cancel_wid)] and decrements inflight[cancel_wid].
- Per-slice net update per cycle = (#pop + #cancel) − #reserve, so the range is −1..+2. Simultaneous reserve and pop on one slice leaves credit unchanged.
- Per-warp net update per cycle = (#reserve) − (#pop + #cancel), so the range is −2..+1. At most one pop per warp per cycle holds, because each warp maps to exactly one slice.
- req_ready = (credit[wid_to_isw(req_wid)] != 0). It is computed from registered state only; there is no same-cycle bypass of pop or cancel. It is driven regardless of req_valid.
- warp_idle[w] = (inflight[w] == 0). It is computed from registered state.
- Illegal input conditions, each flagged with a simulation assertion:
  - credit exceeding CREDITS,
  - credit underflow,
  - inflight underflow,
  - pop while the slice credit == CREDITS.

  On these conditions the counters saturate and do not wrap.

## Timing
- Reset values:
  - credit[*] = CREDITS.
  - inflight[*] = 0.
  - req_ready = 1.
  - warp_idle = all ones.
  - all_idle = 1.
- Latency: a reserve, pop or cancel in cycle N is visible on req_ready and warp_idle in cycle N+1.
- Full slice: req_ready is 0 while credit is 0. A pop in cycle N reopens the slice in N+1, even if a reserve is presented in N.
- Empty boundary: credit == CREDITS means no slot is reserved. A subsequent pop or cancel on that slice is illegal.
- Reset mid-operation: all counters return to reset values in the next cycle, and outstanding reservations are discarded. Upstream and downstream units are reset on the same reset.
- No internal pipeline. Reserve throughput is one per cycle when credit is available.

## Structure
- Add wis_to_wid(wis, isw) to VX_gpu_pkg beside the existing wid_to_isw and wid_to_wis helpers. Reuse NW_WIDTH and ISSUE_WIS_W from the package.
- CNTW is a local parameter. No new typedefs are needed.
- One natural sub-module: VX_up_down_counter, a saturating counter with separate inc (0..2) and dec (0..2) inputs, a reset value parameter and a maximum parameter. It is instantiated ISSUE_CNT times for credits and NUM_WARPS times for inflight.

## Test plan
Configuration: ISSUE_CNT=2, NUM_WARPS=4, CREDITS=2.
- Reset, then idle: req_ready=1 for wid 0..3; warp_idle=4'b1111; all_idle=1.
- Reserve wid0 in two consecutive cycles: slice 0 credit becomes 0, so req_ready=0 for wid0 and wid2 and 1 for wid1 and wid3; warp_idle=4'b1110; all_idle=0.
- With slice 0 full, assert pop[0] (wis 1 means wid2; first reserve wid2 instead) together with req_valid for wid2: req_ready=0 in that cycle and 1 in the next; credit[0]=1.
- Slice 1 at credit 1: reserve wid3 and pop[1]/wis0 (wid1) in the same cycle: credit[1] stays 1; inflight[3]+1 and inflight[1]−1; warp_idle[1] becomes 1 in the next cycle.
- Slice 0 at credit 0 with wid0 holding 2: cancel_wid=0 and pop[0]/wis0 in the same cycle: credit[0]=2 and warp_idle[0]=1 in the next cycle.
- With three warps holding reservations, assert reset for one cycle: the next cycle shows all credits at 2, warp_idle=4'b1111 and req_ready=1.

Source files
------------

// File: rtl/vx_ibuf_credit_pkg.sv
// Shared warp/slice mapping helpers and default configuration for the
// instruction-buffer credit tracker.
package vx_ibuf_credit_pkg;

  localparam int NUM_WARPS_DEF   = 4;
  localparam int ISSUE_WIDTH_DEF = 2;
  localparam int IBUF_SIZE_DEF   = 2;

  function automatic int wid_to_isw(input int wid, input int issue_cnt);
    return wid % issue_cnt;
  endfunction

  function automatic int wid_to_wis(input int wid, input int issue_cnt);
    return wid / issue_cnt;
  endfunction

  function automatic int wis_to_wid(input int wis, input int isw, input int issue_cnt);
    return wis * issue_cnt + isw;
  endfunction

endpackage

// File: rtl/vx_ibuf_credit_up_down_counter.sv
// Saturating up/down counter with independent 0..2 increment and decrement
// per cycle; out-of-range results clamp and raise a simulation assertion.
module vx_ibuf_credit_up_down_counter #(
  parameter int WIDTH     = 2,
  parameter int RESET_VAL = 0,
  parameter int MAX_VAL   = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [1:0]       inc_i,
  input  logic [1:0]       dec_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic signed [WIDTH+2:0] MAX_S = (WIDTH+3)'(MAX_VAL);

  logic [WIDTH-1:0]        cnt_q;
  logic [WIDTH-1:0]        cnt_d;
  logic signed [WIDTH+2:0] sum;

  always_comb begin
    sum = $signed({3'b000, cnt_q})
        + $signed({{(WIDTH+1){1'b0}}, inc_i})
        - $signed({{(WIDTH+1){1'b0}}, dec_i});
    cnt_d = cnt_q;
    if (sum < 0) begin
      cnt_d = '0;
    end else if (sum > MAX_S) begin
      cnt_d = WIDTH'(MAX_VAL);
    end else begin
      cnt_d = sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= WIDTH'(RESET_VAL);
    end else begin
      cnt_q <= cnt_d;
      assert (sum >= 0) else $error("up_down_counter underflow: count %0d", cnt_q);
      assert (sum <= MAX_S) else $error("up_down_counter overflow: count %0d", cnt_q);
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/vx_ibuf_credit.sv
// Per-slice instruction-buffer credit tracker with per-warp in-flight counts.
// Handshake: a reserve fires on req_valid_i && req_ready_o; req_ready_o depends only on registered credit.
module vx_ibuf_credit
  import vx_ibuf_credit_pkg::*;
#(
  parameter int CORE_ID   = 0,
  parameter int NUM_WARPS = NUM_WARPS_DEF,
  parameter int ISSUE_CNT = ISSUE_WIDTH_DEF,
  parameter int CREDITS   = IBUF_SIZE_DEF,
  localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int WIS_PER     = (NUM_WARPS + ISSUE_CNT - 1) / ISSUE_CNT,
  localparam int ISSUE_WIS_W = (WIS_PER > 1) ? $clog2(WIS_PER) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           req_valid_i,
  input  logic [NW_WIDTH-1:0]            req_wid_i,
  output logic                           req_ready_o,
  input  logic [ISSUE_CNT-1:0]           pop_i,
  input  logic [ISSUE_CNT*ISSUE_WIS_W-1:0] pop_wis_i,
  input  logic                           cancel_valid_i,
  input  logic [NW_WIDTH-1:0]            cancel_wid_i,
  output logic [NUM_WARPS-1:0]           warp_idle_o,
  output logic                           all_idle_o
);

  localparam int CNTW = $clog2(CREDITS + 1);

  logic [CNTW-1:0]      credit_cnt   [ISSUE_CNT];
  logic [CNTW-1:0]      inflight_cnt [NUM_WARPS];
  logic [ISSUE_CNT-1:0] slice_sel;
  logic [ISSUE_CNT-1:0] slice_open;
  logic                 req_fire;

  assign req_ready_o = |(slice_sel & slice_open);
  assign req_fire    = req_valid_i && req_ready_o;

  for (genvar i = 0; i < ISSUE_CNT; i++) begin : g_slice
    logic       cancel_hit;
    logic       res_hit;
    logic [1:0] inc;
    logic [1:0] dec;

    assign slice_sel[i]  = (wid_to_isw(int'(req_wid_i), ISSUE_CNT) == i);
    assign slice_open[i] = (credit_cnt[i] != '0);
    assign cancel_hit    = cancel_valid_i && (wid_to_isw(int'(cancel_wid_i), ISSUE_CNT) == i);
    assign res_hit       = req_fire && slice_sel[i];
    assign inc           = {1'b0, pop_i[i]} + {1'b0, cancel_hit};
    assign dec           = {1'b0, res_hit};

    vx_ibuf_credit_up_down_counter #(
      .WIDTH    (CNTW),
      .RESET_VAL(CREDITS),
      .MAX_VAL  (CREDITS)
    ) u_credit (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .inc_i  (inc),
      .dec_i  (dec),
      .count_o(credit_cnt[i])
    );

    // A pop with no slot reserved on its slice means the buffer and tracker disagree.
    always_ff @(posedge clk_i) begin
      if (!reset_i && pop_i[i]) begin
        assert (credit_cnt[i] != CNTW'(CREDITS))
          else $error("core %0d: pop on slice %0d with no reserved slot", CORE_ID, i);
      end
    end
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    logic [ISSUE_CNT-1:0] pop_hit;
    logic                 cancel_hit;
    logic [1:0]           inc;
    logic [1:0]           dec;

    for (genvar i = 0; i < ISSUE_CNT; i++) begin : g_pop
      assign pop_hit[i] = pop_i[i] &&
        (wis_to_wid(int'(pop_wis_i[i*ISSUE_WIS_W +: ISSUE_WIS_W]), i, ISSUE_CNT) == w);
    end

    assign cancel_hit = cancel_valid_i && (cancel_wid_i == NW_WIDTH'(w));
    assign inc        = {1'b0, req_fire && (req_wid_i == NW_WIDTH'(w))};
    assign dec        = {1'b0, |pop_hit} + {1'b0, cancel_hit};

    vx_ibuf_credit_up_down_counter #(
      .WIDTH    (CNTW),
      .RESET_VAL(0),
      .MAX_VAL  (CREDITS)
    ) u_inflight (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .inc_i  (inc),
      .dec_i  (dec),
      .count_o(inflight_cnt[w])
    );

    assign warp_idle_o[w] = (inflight_cnt[w] == '0);
  end

  assign all_idle_o = &warp_idle_o;

endmodule
